// File: rtl/imm_encoder.sv
// Immediate encoder: merges a signed immediate into an I/S/B instruction word.
// Two-stage valid/ready pipeline with range checking and a saturating error counter.
module imm_encoder #(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_base,
  input  logic [31:0]          in_imm,
  input  logic [1:0]           in_fmt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_ir,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    FmtI   = 2'b00,
    FmtS   = 2'b01,
    FmtB   = 2'b10,
    FmtBad = 2'b11
  } fmt_e;

  // Stage 1: captured fields plus the range/alignment verdict
  logic                 s1_valid_q;
  logic [31:0]          s1_base_q;
  logic [12:0]          s1_imm_q;
  fmt_e                 s1_fmt_q;
  logic                 s1_err_q;

  // Stage 2: merged instruction word
  logic                 s2_valid_q;
  logic [31:0]          s2_ir_q;
  logic                 s2_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  fmt_e        in_fmt_e;
  logic        fits_12;
  logic        fits_13;
  logic        in_err;
  logic        s1_load;
  logic        s2_load;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] ir_merged;

  assign in_fmt_e = fmt_e'(in_fmt);

  // Signed value fits in N bits when every bit above N-1 copies bit N-1
  assign fits_12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
  assign fits_13 = (&in_imm[31:12]) || !(|in_imm[31:12]);

  always_comb begin
    in_err = 1'b1;
    unique case (in_fmt_e)
      FmtI, FmtS: in_err = !fits_12;
      FmtB:       in_err = !fits_13 || in_imm[0];
      default:    in_err = 1'b1;
    endcase
  end

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = rst_n && s1_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_valid_q && out_ready;

  always_comb begin
    ir_merged = s1_base_q;
    if (!s1_err_q) begin
      unique case (s1_fmt_q)
        FmtI: begin
          ir_merged[31:20] = s1_imm_q[11:0];
        end
        FmtS: begin
          ir_merged[31:25] = s1_imm_q[11:5];
          ir_merged[11:7]  = s1_imm_q[4:0];
        end
        FmtB: begin
          ir_merged[31]    = s1_imm_q[12];
          ir_merged[7]     = s1_imm_q[11];
          ir_merged[30:25] = s1_imm_q[10:5];
          ir_merged[11:8]  = s1_imm_q[4:1];
        end
        default: ir_merged = s1_base_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_base_q  <= '0;
      s1_imm_q   <= '0;
      s1_fmt_q   <= FmtI;
      s1_err_q   <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= in_fire;
      if (in_fire) begin
        s1_base_q <= in_base;
        s1_imm_q  <= in_imm[12:0];
        s1_fmt_q  <= in_fmt_e;
        s1_err_q  <= in_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_ir_q    <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_ir_q  <= ir_merged;
        s2_err_q <= s1_err_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (out_fire && s2_err_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign out_valid = s2_valid_q;
  assign out_ir    = s2_ir_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 16, width of the saturating error counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset: synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, request beat present.
REQ-005 SHALL have port in_ready, output, 1, block accepts the beat this cycle.
REQ-006 SHALL have port in_base, input, 32, instruction word with opcode, rd, rs1, rs2 and funct fields already set.
REQ-007 SHALL have port in_imm, input, 32, signed immediate value to encode.
REQ-008 SHALL have port in_fmt, input, 2, format select: 00 I, 01 S, 10 B, 11 illegal.
REQ-009 SHALL have port out_valid, output, 1, result beat present.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port out_ir, output, 32, encoded instruction word.
REQ-012 SHALL have port out_err, output, 1, this beat failed encoding.
REQ-013 SHALL have port err_cnt, output, ERR_CNT_W, count of errored beats delivered.

Function
REQ-014 SHALL transfer a beat on any edge where valid and ready are both high, at both input and output.
REQ-015 SHALL be a 2-stage pipeline: S1 registers the checked fields and error flag; S2 registers the merged word.
REQ-016 SHALL present out_valid 2 cycles after acceptance when not stalled, at a throughput of 1 beat per cycle.
REQ-017 SHALL let each stage load when it is empty or when its contents move forward that cycle; in_ready = !S1_valid || S2 loads.
REQ-018 SHALL hold out_ir and out_err stable while out_valid=1 and out_ready=0, with no beat lost or duplicated.
REQ-019 I format: out_ir[31:20] = imm[11:0]; legal only for -2048 <= imm <= 2047.
REQ-020 S format: out_ir[31:25] = imm[11:5] and out_ir[11:7] = imm[4:0]; same legal range as I.
REQ-021 B format: out_ir[31] = imm[12], [7] = imm[11], [30:25] = imm[10:5], [11:8] = imm[4:1]; legal only for -4096 <= imm <= 4094 with imm[0] = 0.
REQ-022 SHALL overwrite only the immediate bit positions of the selected format; all other bits pass from in_base unchanged.
REQ-023 SHALL define the range check as: in_imm[31:N] all equal to in_imm[N-1], with N = 12 for I/S and N = 13 for B.
REQ-024 On fmt 11, out-of-range or misaligned B: out_err = 1 and out_ir = in_base unmodified.
REQ-025 SHALL increment err_cnt on each output transfer with out_err = 1, saturating at all-ones (no wrap).
REQ-026 SHALL let a simultaneous input accept and output transfer on a full pipeline proceed in the same cycle with no bubble.

Reset
REQ-027 While rst_n = 0 at an edge, SHALL set S1_valid = S2_valid = 0, out_valid = 0, out_err = 0, out_ir = 0 and err_cnt = 0.
REQ-028 SHALL hold in_ready = 0 during reset and drive it to 1 the first cycle after rst_n rises.
REQ-029 Reset mid-operation SHALL discard all in-flight beats, with no output transfer for them afterwards.

Verification
REQ-030 I: base 0x00000093, imm 0xFFFFFFFF, fmt 00, out_ready = 1 -> out_ir 0xFFF00093, out_err 0, exactly 2 cycles after accept.
REQ-031 S then B back-to-back: base 0x00002023 imm 8 fmt 01 -> 0x00002423; base 0x00000063 imm -4 fmt 10 -> 0xFE000EE3, on consecutive cycles.
REQ-032 Errors: B imm 3; I imm 2048; fmt 11 with base 0x13 -> each gives out_err 1, out_ir = base, and err_cnt ends at 3.
REQ-033 Backpressure: 4 beats offered with out_ready = 0 for 5 cycles -> in_ready falls after 2 accepted, then all 4 delivered in order, unaltered.
REQ-034 Reset with 2 beats in flight -> out_valid 0 next cycle, err_cnt 0, and no stale beat appears.
REQ-035 Saturation with ERR_CNT_W = 2: 5 errored beats -> err_cnt reads 3.
